// File: rtl/uart_bus_pkg.sv
// Shared definitions for the UART register bus: address map, FSM encoding and
// default widths used by both the bus master and the register-side decode.
package uart_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned DATA_W_DEF = 32;

  localparam logic [ADDR_W_DEF-1:0] ADDR_DATA = 10'd0;
  localparam logic [ADDR_W_DEF-1:0] ADDR_CTRL = 10'd2;
  localparam logic [ADDR_W_DEF-1:0] ADDR_BAUD = 10'd4;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSetup  = 2'd1,
    StAccess = 2'd2,
    StResp   = 2'd3
  } state_e;

  function automatic logic addr_mapped(input logic [ADDR_W_DEF-1:0] a);
    return (a == ADDR_DATA) || (a == ADDR_CTRL) || (a == ADDR_BAUD);
  endfunction

endpackage

// File: rtl/uart_bus_timeout.sv
// Loadable down-counter bounding the ACCESS phase; expired is high at zero.
module uart_bus_timeout #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_dec,
  input  logic i_clr,
  output logic o_expired
);

  localparam int unsigned     CntW    = 8;
  // Loaded with TIMEOUT-1 so that exactly TIMEOUT ACCESS cycles elapse before expiry.
  localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= LoadVal;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/uart_bus_master.sv
// Command/response to two-phase SETUP/ACCESS bus initiator for the UART register block,
// with address-map filtering and an ACCESS-phase timeout.
module uart_bus_master
  import uart_bus_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_sel,
  output logic              o_enable,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_write,
  output logic [DATA_W-1:0] o_wdata,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_ready
);

  state_e r_state, w_state_d;

  logic              r_sel, w_sel_d;
  logic              r_enable, w_enable_d;
  logic [ADDR_W-1:0] r_addr, w_addr_d;
  logic              r_write, w_write_d;
  logic [DATA_W-1:0] r_wdata, w_wdata_d;
  logic              r_rsp_valid, w_rsp_valid_d;
  logic [DATA_W-1:0] r_rsp_rdata, w_rsp_rdata_d;
  logic              r_rsp_err, w_rsp_err_d;

  logic w_cmd_mapped;
  logic w_tmo_load, w_tmo_dec, w_tmo_clr, w_tmo_expired;

  assign w_cmd_mapped = addr_mapped(ADDR_W_DEF'(i_cmd_addr));

  uart_bus_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_load   (w_tmo_load),
    .i_dec    (w_tmo_dec),
    .i_clr    (w_tmo_clr),
    .o_expired(w_tmo_expired)
  );

  always_comb begin
    w_state_d     = r_state;
    w_sel_d       = r_sel;
    w_enable_d    = r_enable;
    w_addr_d      = r_addr;
    w_write_d     = r_write;
    w_wdata_d     = r_wdata;
    w_rsp_valid_d = r_rsp_valid;
    w_rsp_rdata_d = r_rsp_rdata;
    w_rsp_err_d   = r_rsp_err;
    w_tmo_load    = 1'b0;
    w_tmo_dec     = 1'b0;
    w_tmo_clr     = 1'b0;

    unique case (r_state)
      StIdle: begin
        if (i_cmd_valid) begin
          if (w_cmd_mapped) begin
            w_state_d = StSetup;
            w_sel_d   = 1'b1;
            w_addr_d  = i_cmd_addr;
            w_write_d = i_cmd_write;
            w_wdata_d = i_cmd_wdata;
          end else begin
            // Unmapped: answer with an error without touching the bus.
            w_state_d     = StResp;
            w_rsp_valid_d = 1'b1;
            w_rsp_err_d   = 1'b1;
            w_rsp_rdata_d = '0;
          end
        end
      end

      StSetup: begin
        w_state_d  = StAccess;
        w_enable_d = 1'b1;
        w_tmo_load = 1'b1;
      end

      StAccess: begin
        // ready is checked first so completion wins over a simultaneous expiry.
        if (i_ready || w_tmo_expired) begin
          w_state_d     = StResp;
          w_rsp_valid_d = 1'b1;
          w_rsp_err_d   = !i_ready;
          w_rsp_rdata_d = (i_ready && !r_write) ? i_rdata : '0;
          w_sel_d       = 1'b0;
          w_enable_d    = 1'b0;
          w_addr_d      = '0;
          w_write_d     = 1'b0;
          w_wdata_d     = '0;
          w_tmo_clr     = 1'b1;
        end else begin
          w_tmo_dec = 1'b1;
        end
      end

      StResp: begin
        if (i_rsp_ready) begin
          w_state_d     = StIdle;
          w_rsp_valid_d = 1'b0;
        end
      end

      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_sel       <= 1'b0;
      r_enable    <= 1'b0;
      r_addr      <= '0;
      r_write     <= 1'b0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_sel       <= w_sel_d;
      r_enable    <= w_enable_d;
      r_addr      <= w_addr_d;
      r_write     <= w_write_d;
      r_wdata     <= w_wdata_d;
      r_rsp_valid <= w_rsp_valid_d;
      r_rsp_rdata <= w_rsp_rdata_d;
      r_rsp_err   <= w_rsp_err_d;
    end
  end

  assign o_cmd_ready = rst_n && (r_state == StIdle);
  assign o_sel       = r_sel;
  assign o_enable    = r_enable;
  assign o_addr      = r_addr;
  assign o_write     = r_write;
  assign o_wdata     = r_wdata;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_uart_bus_master.sv
// Scoreboard bench for uart_bus_master: directed transfers, timing checks in the
// stimulus thread, response contents checked by a separate monitor.
module tb_uart_bus_master;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [9:0]  i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic        o_sel;
  logic        o_enable;
  logic [9:0]  o_addr;
  logic        o_write;
  logic [31:0] o_wdata;
  logic [31:0] i_rdata;
  logic        i_ready;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  uart_bus_master #(
    .ADDR_W (10),
    .DATA_W (32),
    .TIMEOUT(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready),
    .i_cmd_write(i_cmd_write),
    .i_cmd_addr (i_cmd_addr),
    .i_cmd_wdata(i_cmd_wdata),
    .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready),
    .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_err  (o_rsp_err),
    .o_sel      (o_sel),
    .o_enable   (o_enable),
    .o_addr     (o_addr),
    .o_write    (o_write),
    .o_wdata    (o_wdata),
    .i_rdata    (i_rdata),
    .i_ready    (i_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Response monitor: consumes one expectation per response handshake.
  always @(negedge clk) begin
    if (rst_n && o_rsp_valid && i_rsp_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got rdata=%0h err=%0b, required no response",
                 o_rsp_rdata, o_rsp_err);
      end else begin
        mon_e = exp_q.pop_front();
        if ({o_rsp_err, o_rsp_rdata} !== {mon_e.err, mon_e.rdata}) begin
          n_fail++;
          $display("FAIL rsp_data: got rdata=%0h err=%0b, required rdata=%0h err=%0b",
                   o_rsp_rdata, o_rsp_err, mon_e.rdata, mon_e.err);
        end
      end
    end
  end

  // ready_k: 0 = ready high from the start, n = ready rises after the n-th edge past
  // acceptance, large = never. hold = cycles of rsp_ready backpressure.
  task automatic xfer(input string name, input logic wr, input logic [9:0] a,
                      input logic [31:0] wd, input int ready_k, input logic [31:0] rd,
                      input logic [31:0] exp_rd, input logic exp_err, input int exp_en,
                      input int exp_lat, input int hold);
    int          en_cnt, sel_cnt, lat, stable_bad, rdy_bad, hold_bad;
    logic [31:0] cap_rd;
    logic        cap_err;
    exp_t        e;
    en_cnt = 0; sel_cnt = 0; lat = 0; stable_bad = 0; rdy_bad = 0; hold_bad = 0;
    @(posedge clk); #1;
    i_ready     = (ready_k == 0);
    i_rdata     = (ready_k == 0) ? rd : 32'hBAD0_BAD0;
    i_rsp_ready = (hold == 0);
    e.rdata = exp_rd;
    e.err   = exp_err;
    exp_q.push_back(e);
    i_cmd_valid = 1'b1;
    i_cmd_write = wr;
    i_cmd_addr  = a;
    i_cmd_wdata = wd;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    i_cmd_write = ~wr;
    i_cmd_addr  = ~a;
    i_cmd_wdata = ~wd;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (o_rsp_valid) begin
        lat = k + 1;
        break;
      end
      if (o_cmd_ready) rdy_bad++;
      if (o_sel) sel_cnt++;
      if (o_enable) en_cnt++;
      if (k == 0 && exp_en > 0)
        check({name, "_setup"}, {o_sel, o_enable, o_write, o_addr, o_wdata},
              {1'b1, 1'b0, wr, a, wd});
      if (o_sel && ({o_write, o_addr, o_wdata} !== {wr, a, wd})) stable_bad++;
      @(posedge clk); #1;
      if (ready_k > 0 && k == ready_k - 1) begin
        i_ready = 1'b1;
        i_rdata = rd;
      end
    end
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_enable_cycles"}, en_cnt, exp_en);
    check({name, "_sel_cycles"}, sel_cnt, (exp_en > 0) ? exp_en + 1 : 0);
    check({name, "_bus_stable"}, stable_bad, 0);
    check({name, "_cmd_ready_low"}, rdy_bad, 0);
    check({name, "_bus_idle_at_rsp"}, {o_sel, o_enable, o_write, o_addr, o_wdata}, 0);
    cap_rd  = o_rsp_rdata;
    cap_err = o_rsp_err;
    if (hold > 0) begin
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        if (!o_rsp_valid || o_cmd_ready || o_rsp_rdata !== cap_rd || o_rsp_err !== cap_err)
          hold_bad++;
      end
      check({name, "_rsp_hold"}, hold_bad, 0);
      @(posedge clk); #1;
      i_rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(negedge clk);
    check({name, "_back_idle"}, {o_cmd_ready, o_rsp_valid}, 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stale;
    rst_n       = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'b0;
    i_cmd_addr  = '0;
    i_cmd_wdata = '0;
    i_rsp_ready = 1'b1;
    i_rdata     = '0;
    i_ready     = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("reset_ctrl", {o_cmd_ready, o_rsp_valid, o_rsp_err, o_sel, o_enable, o_write}, 0);
    check("reset_data", {o_addr, o_wdata, o_rsp_rdata}, 0);
    #20 rst_n = 1'b1;
    @(negedge clk);
    check("reset_release_ready", o_cmd_ready, 1'b1);

    //   name          wr    addr    wdata          rk   rdata          exp_rd         err  en lat hold
    xfer("wr_baud",    1'b1, 10'd4,  32'h0000_01B2, 0,   32'hFFFF_FFFF, 32'h0,         1'b0, 1, 3, 0);
    xfer("rd_wait",    1'b0, 10'd0,  32'h0,         6,   32'h0000_0041, 32'h0000_0041, 1'b0, 6, 8, 0);
    xfer("unmapped3",  1'b0, 10'd3,  32'h0,         0,   32'h0000_1234, 32'h0,         1'b1, 0, 1, 0);
    xfer("unmap_3ff",  1'b1, 10'h3FF, 32'hA5A5_A5A5, 0,  32'h0000_5678, 32'h0,         1'b1, 0, 1, 0);
    xfer("timeout",    1'b0, 10'd2,  32'h0,         999, 32'h0000_0077, 32'h0,         1'b1, 16, 18, 0);
    xfer("rd_bp",      1'b0, 10'd4,  32'h0,         0,   32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1, 3, 10);
    xfer("wr_last",    1'b1, 10'd2,  32'hDEAD_BEEF, 16,  32'h0000_5555, 32'h0,         1'b0, 16, 18, 0);
    xfer("rd_15",      1'b0, 10'd0,  32'h0,         15,  32'h8000_0001, 32'h8000_0001, 1'b0, 15, 17, 0);
    xfer("tmo_bp",     1'b1, 10'd0,  32'h0000_0001, 999, 32'h0,         32'h0,         1'b1, 16, 18, 4);

    // Reset in the middle of an ACCESS phase; no response may follow.
    @(posedge clk); #1;
    i_ready     = 1'b0;
    i_rsp_ready = 1'b1;
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_addr  = 10'd2;
    @(posedge clk); #1;
    i_cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_pre", {o_sel, o_enable}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_async", {o_cmd_ready, o_rsp_valid, o_sel, o_enable}, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    i_ready = 1'b1;
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (o_rsp_valid || o_sel) stale++;
    end
    check("rst_no_stale", stale, 0);
    check("rst_cmd_ready", o_cmd_ready, 1'b1);

    xfer("post_rst",   1'b1, 10'd2,  32'h0000_0003, 0,   32'h0,         32'h0,         1'b0, 1, 3, 0);

    repeat (2) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_bus_master.md
Name: uart_bus_master

Overview:
- Bus-side initiator for the UART register block. It converts a simple command/response stream into two-phase SETUP/ACCESS transfers on the peripheral select bus (sel, enable, addr[11:2], write, wdata, rdata, ready).
- Sits between the CPU-side command source, or test sequencer, and the UART register decode.
- Provides address-map checking and an access timeout so a hung peripheral cannot stall the command source.

Parameters:
- ADDR_W, 10, word-address width; bus carries byte-address bits [11:2]
- DATA_W, 32, data width of wdata/rdata/cmd/rsp
- TIMEOUT, 16, maximum ACCESS cycles waiting for ready before an error response (legal range 2..255)

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  master can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_W  word address [11:2]
- cmd_wdata  in  DATA_W  write data
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer accepts
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors
- rsp_err  out  1  1 = unmapped address or timeout
- sel  out  1  peripheral select
- enable  out  1  access phase strobe
- addr  out  ADDR_W  bus word address
- write  out  1  bus direction
- wdata  out  DATA_W  bus write data
- rdata  in  DATA_W  bus read data
- ready  in  1  peripheral completes access when high in ACCESS

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low.
- Reset values while rst_n = 0:
  - state = IDLE
  - sel, enable, write, rsp_valid, rsp_err = 0
  - addr, wdata, rsp_rdata = 0
  - timeout counter = 0
  - cmd_ready = 0, because it is gated by rst_n
- Reset asserted mid-transfer: bus strobes drop immediately, and any pending command or response is discarded.
- All bus outputs and rsp_* outputs are registered. cmd_ready = rst_n AND (state == IDLE).
- FSM states are IDLE, SETUP, ACCESS, RESP.
  - IDLE: a command is accepted on an edge where cmd_valid && cmd_ready, and cmd_write, cmd_addr and cmd_wdata are captured.
    - If cmd_addr is in the map (ADDR_DATA = 0, ADDR_CTRL = 2, ADDR_BAUD = 4), go to SETUP.
    - Otherwise go directly to RESP with rsp_err = 1 and rsp_rdata = 0. No bus cycle is issued.
  - SETUP (exactly 1 cycle): sel = 1, enable = 0; addr, write and wdata are driven. Next state is ACCESS.
  - ACCESS: sel = 1, enable = 1; addr, write and wdata are held stable.
    - ready = 1 at an edge: capture rdata (reads) or 0 (writes) into rsp_rdata, set rsp_err = 0, go to RESP.
    - ready = 0: increment the counter. When the counter reaches TIMEOUT-1 with ready still low, go to RESP with rsp_err = 1 and rsp_rdata = 0.
    - ready high on the same edge the counter reaches TIMEOUT-1 counts as success; completion wins over timeout.
  - Leaving ACCESS, by either path, clears sel, enable, addr, write, wdata and the counter on that same edge.
  - RESP: rsp_valid = 1; rsp_rdata and rsp_err are held until the edge where rsp_ready = 1, then go to IDLE with rsp_valid = 0.
- Latency:
  - Mapped transfer with ready already high: command accepted at edge 0, SETUP in cycle 1, ACCESS in cycle 2, rsp_valid in cycle 3.
  - Unmapped address: rsp_valid 1 cycle after acceptance.
- Throughput: one outstanding command. The next command can be accepted the cycle after the response handshake; minimum 4 cycles per mapped transfer.
- Input sampling: ready is sampled only in ACCESS; ready in other states is ignored. rdata is sampled only on the completing edge.
- Changes to cmd_* while cmd_ready = 0 have no effect.

Decomposition:
- Shared package uart_bus_pkg holds:
  - address constants ADDR_DATA = 10'd0, ADDR_CTRL = 10'd2, ADDR_BAUD = 10'd4
  - the state encoding: IDLE = 2'd0, SETUP = 2'd1, ACCESS = 2'd2, RESP = 2'd3
  - DATA_W and ADDR_W defaults
- The address map is shared with the register-side decode.
- One natural sub-module: uart_bus_timeout, a loadable down-counter with expire flag, parameterized by TIMEOUT. Everything else stays in the top FSM.

Test Plan:
- Write baud: cmd_write = 1, cmd_addr = 4, cmd_wdata = 32'h0000_01B2, ready tied 1.
  -> sel rises the cycle after acceptance, with enable = 0, addr = 4, wdata = 32'h1B2.
  -> enable = 1 the next cycle.
  -> rsp_valid = 1 three cycles after acceptance, rsp_err = 0, rsp_rdata = 0.
- Read data with wait states: cmd_write = 0, addr 0, ready held low for 5 ACCESS cycles then high with rdata = 32'h0000_0041.
  -> enable held 6 cycles.
  -> rsp_rdata = 32'h41, rsp_err = 0.
  -> sel/enable low on the cycle rsp_valid rises.
- Unmapped address: cmd_addr = 3.
  -> sel never asserts.
  -> rsp_valid 1 cycle after acceptance, rsp_err = 1, rsp_rdata = 0.
- Timeout: TIMEOUT = 16, addr 2, ready stuck 0.
  -> exactly 16 ACCESS cycles.
  -> rsp_err = 1.
  -> next command accepted after rsp_ready.
- Response backpressure: rsp_ready held 0 for 10 cycles.
  -> rsp_valid, rsp_rdata and rsp_err stable; cmd_ready = 0 throughout.
  -> IDLE and cmd_ready = 1 the cycle after rsp_ready = 1.
- Reset mid-ACCESS: pull rst_n low while enable = 1.
  -> sel, enable and rsp_valid go 0 asynchronously.
  -> after release, cmd_ready = 1 and no stale response appears.
